// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encodings and elaboration-time helpers for digit count and counter width.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of digit steps needed to cover the full operand width.
    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; at least one bit even when a single step suffices.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_rca.sv
// DIGIT-bit ripple-carry adder. Besides the sum and carry out it exposes the
// carry into its MSB so the caller can derive two's-complement overflow.
module digit_rca #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] carry_s;

    // Bit-by-bit ripple of the carry through the digit.
    always_comb begin
        carry_s    = '0;
        sum        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry_s[DIGIT];
    assign cmsb = carry_s[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor. One operand pair is accepted per valid/ready
// handshake and processed DIGIT bits per clock, LSB digit first, through one
// shared ripple-carry digit adder. Subtraction is A + ~B + 1.
module serial_add_sub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = digit_count(WIDTH, DIGIT);
    localparam int CW = cnt_width(N);

    state_e           state_r;
    state_e           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sub_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic             out_valid_r;
    logic             in_ready_r;

    logic             load_s;
    logic             step_s;
    logic             last_s;
    int               base_s;
    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT-1:0] sum_s;
    logic             rca_cout_s;
    logic             rca_cmsb_s;
    logic [WIDTH-1:0] result_next_s;

    assign last_s = (cnt_r == CW'(N - 1));

    // Next-state and control decode for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Select the current digit of A and of B (inverted when subtracting).
    always_comb begin
        base_s  = int'(cnt_r) * DIGIT;
        a_dig_s = a_r[base_s +: DIGIT];
        if (sub_r) begin
            b_dig_s = ~b_r[base_s +: DIGIT];
        end else begin
            b_dig_s = b_r[base_s +: DIGIT];
        end
    end

    digit_rca #(
        .DIGIT(DIGIT)
    ) u_digit_rca (
        .a    (a_dig_s),
        .b    (b_dig_s),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (rca_cout_s),
        .cmsb (rca_cmsb_s)
    );

    // Result with the current digit merged in; zero is judged on this word.
    always_comb begin
        result_next_s                  = result_r;
        result_next_s[base_s +: DIGIT] = sum_s;
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s == ST_DONE);
            in_ready_r  <= (state_s == ST_IDLE);
        end
    end

    // Operand capture, digit iteration and final flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else if (load_s) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= subtract;
            cnt_r   <= '0;
            carry_r <= subtract;
        end else if (step_s) begin
            result_r <= result_next_s;
            carry_r  <= rca_cout_s;
            if (last_s) begin
                // Counter parks at N-1; it is only cleared on the next accept.
                cout_r <= rca_cout_s;
                ovf_r  <= rca_cout_s ^ rca_cmsb_s;
                zero_r <= (result_next_s == '0);
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            // Hold everything, keeping outputs stable while DONE waits.
            cnt_r <= cnt_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cout      = cout_r;
    assign overflow  = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: four configurations (16/4, 16/1, 16/16, 4/4)
// driven from shared operands, with a per-instance expected-result queue.
module tb_serial_add_sub;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  iv, ordy, ir, ov, co, of, zr;
    logic [15:0] a_s, b_s;
    logic        sub_s;
    logic [15:0] res [4];
    logic [3:0]  res3;

    int errors = 0;
    int checks = 0;

    logic [18:0] exp_q [4][$];
    int          lat_n [4] = '{4, 16, 1, 1};
    int          wid   [4] = '{16, 16, 16, 4};

    assign res[3] = {12'h000, res3};

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s), .b(b_s),
        .subtract(sub_s), .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]),
        .cout(co[0]), .overflow(of[0]), .zero(zr[0]));
    serial_add_sub #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s), .b(b_s),
        .subtract(sub_s), .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]),
        .cout(co[1]), .overflow(of[1]), .zero(zr[1]));
    serial_add_sub #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s), .b(b_s),
        .subtract(sub_s), .out_valid(ov[2]), .out_ready(ordy[2]), .result(res[2]),
        .cout(co[2]), .overflow(of[2]), .zero(zr[2]));
    serial_add_sub #(.WIDTH(4), .DIGIT(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .a(a_s[3:0]), .b(b_s[3:0]),
        .subtract(sub_s), .out_valid(ov[3]), .out_ready(ordy[3]), .result(res3),
        .cout(co[3]), .overflow(of[3]), .zero(zr[3]));

    // Golden model: {zero, overflow, cout, result[15:0]} for a w-bit operation.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic msub, input int w);
        logic [15:0] mask, am, bm, r;
        logic [16:0] s;
        logic        c, v;
        mask = (w == 16) ? 16'hFFFF : 16'h000F;
        am   = ma & mask;
        bm   = (msub ? ~mb : mb) & mask;
        s    = {1'b0, am} + {1'b0, bm} + {16'h0000, msub};
        r    = s[15:0] & mask;
        c    = s[w];
        v    = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
        return {(r == 16'h0000), v, c, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one operand pair into all four instances and retire every result.
    task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
        logic [18:0] e;
        logic [3:0]  done;
        int          cyc;
        @(negedge clk);
        chk("in_ready_before_accept", {28'h0, ir}, 32'hF);
        a_s = ta; b_s = tb; sub_s = ts; iv = 4'hF;
        for (int i = 0; i < 4; i++) exp_q[i].push_back(model(ta, tb, ts, wid[i]));
        @(posedge clk); #1;
        iv = 4'h0; a_s = 16'($urandom); b_s = 16'($urandom); sub_s = ~ts;
        chk("in_ready_low_after_accept", {28'h0, ir}, 32'h0);
        done = 4'h0;
        cyc  = 0;
        while (done != 4'hF && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (!done[i] && ov[i]) begin
                    done[i] = 1'b1;
                    chk($sformatf("latency_%0d", i), cyc, lat_n[i]);
                    chk($sformatf("queue_nonempty_%0d", i), exp_q[i].size() > 0, 1);
                    if (exp_q[i].size() > 0) begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("result_%0d", i), res[i], e[15:0]);
                        chk($sformatf("cout_%0d", i), co[i], e[16]);
                        chk($sformatf("overflow_%0d", i), of[i], e[17]);
                        chk($sformatf("zero_%0d", i), zr[i], e[18]);
                    end
                end
            end
        end
        chk("all_results_within_budget", {28'h0, done}, 32'hF);
        @(posedge clk); #1;
        chk("out_valid_drops_after_handshake", {28'h0, ov}, 32'h0);
    endtask

    initial begin
        logic [18:0] e;
        rst_n = 1'b0; iv = 4'h0; ordy = 4'hF; a_s = 16'h0; b_s = 16'h0; sub_s = 1'b0;
        #12;
        chk("reset_out_valid", {28'h0, ov}, 32'h0);
        chk("reset_in_ready", {28'h0, ir}, 32'hF);
        chk("reset_result", res[0], 32'h0);
        chk("reset_flags", {co[0], of[0], zr[0]}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Directed arithmetic cases.
        run_txn(16'h1234, 16'h0FFF, 1'b0);
        run_txn(16'h0005, 16'h0007, 1'b1);
        run_txn(16'h8000, 16'h0001, 1'b1);
        run_txn(16'h7FFF, 16'h0001, 1'b0);
        run_txn(16'hABCD, 16'hABCD, 1'b1);
        run_txn(16'hFFFF, 16'h0001, 1'b0);
        run_txn(16'h0009, 16'h0003, 1'b1);

        // Backpressure on the 16/4 instance only.
        @(negedge clk);
        e = model(16'h1111, 16'h2222, 1'b0, 16);
        a_s = 16'h1111; b_s = 16'h2222; sub_s = 1'b0; iv = 4'b0001; ordy = 4'b1110;
        @(posedge clk); #1;
        a_s = 16'hFFFF; b_s = 16'hFFFF; sub_s = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            iv[0] = ~iv[0];
            chk("bp_in_ready_run", ir[0], 0);
            chk("bp_out_valid_timing", ov[0], (k == 4) ? 1 : 0);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            iv[0] = ~iv[0];
            chk("bp_hold_out_valid", ov[0], 1);
            chk("bp_hold_in_ready", ir[0], 0);
            chk("bp_hold_result", res[0], e[15:0]);
            chk("bp_hold_flags", {co[0], of[0], zr[0]}, {e[18], e[17], e[16]});
        end
        @(negedge clk); iv = 4'h0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", ov[0], 0);
        chk("bp_release_in_ready", ir[0], 1);
        @(negedge clk); ordy = 4'hF;

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        a_s = 16'h4321; b_s = 16'h1234; sub_s = 1'b0; iv = 4'hF;
        @(posedge clk); #1; iv = 4'h0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {28'h0, ov}, 32'h0);
        chk("rst_mid_in_ready", {28'h0, ir}, 32'hF);
        chk("rst_mid_result", res[0], 32'h0);
        chk("rst_mid_flags", {co[0], of[0], zr[0]}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        run_txn(16'h0001, 16'h0001, 1'b0);

        // Random operands across all configurations.
        for (int t = 0; t < 20; t++) begin
            run_txn(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised multi-cycle adder/subtractor: the width-generic successor of our 4-bit add/sub block. It accepts one operand pair per transaction over a valid/ready handshake. It processes the operands DIGIT bits per clock, LSB digit first, through a single DIGIT-bit ripple-carry adder. It returns the sum or difference with carry, signed-overflow and zero flags. It sits in the datapath wherever a wide add/sub is needed but a full-width carry chain would not close timing or area.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per clock; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- subtract  input  1  0: A+B; 1: A−B.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. For subtract, 1 means no borrow (A ≥ B unsigned).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

## Operation
- N = WIDTH/DIGIT digit steps per transaction.
- Subtraction is computed as A + ~B + 1: B is inverted per digit and the initial carry-in is 1. Addition uses carry-in 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a, b, subtract; clear the digit counter; load the carry register with subtract; go to RUN.
  - RUN: each cycle adds digit i of A and digit i of (B or ~B) with the carry register. Write the digit into result[i*DIGIT +: DIGIT]; update the carry; increment i. After digit N−1, latch cout and overflow and go to DONE.
  - DONE: out_valid=1. On out_ready go to IDLE; otherwise hold.
- overflow = carry into MSB XOR carry out of MSB, taken from the final digit step.
- zero is evaluated on the complete result and is registered with out_valid.
- in_ready is low in RUN and DONE. in_valid in those states is ignored; no queuing.
- Inputs a, b, subtract may change freely after acceptance; the latched copies are used.
- result, cout, overflow, zero are stable for the whole time out_valid is high.

## Timing
- Reset (rst_n=0, asynchronous, any state including mid-RUN):
  - State goes to IDLE; in_ready=1 once the FSM is in IDLE.
  - out_valid=0; result=0, cout=0, overflow=0, zero=0.
  - Digit counter and carry are cleared; a partial transaction is discarded.
- Latency: accept on edge E0 → out_valid rises after edge E0+N.
  - DIGIT=WIDTH gives 1 cycle.
  - DIGIT=1 gives WIDTH cycles.
- Throughput: one transaction per N+2 cycles at best (IDLE, N×RUN, DONE with out_ready=1).
- Output handshake completes on the edge where out_valid & out_ready. The next accept is possible on the following edge.
- out_ready high before out_valid has no effect.
- The digit counter wraps only by returning to IDLE; it never exceeds N−1.

## Structure
- Shared package/header `addsub_pkg`:
  - FSM state encodings (ST_IDLE, ST_RUN, ST_DONE).
  - Function or macro for the digit count, N = WIDTH/DIGIT.
  - Counter width, clog2(N) with a minimum of 1.
- One sub-module, `digit_rca`, instantiated once:
  - Parametrised DIGIT-bit ripple-carry adder.
  - Outputs: sum, carry out, and carry into its MSB (needed for overflow).
- Top level holds the FSM, operand/result registers and the B-inversion muxing.

## Test plan
- WIDTH=16, DIGIT=4, add 0x1234+0x0FFF → result 0x2233, cout=0, overflow=0, zero=0; out_valid exactly 4 cycles after accept.
- Subtract 0x0005−0x0007 → 0xFFFE, cout=0 (borrow), overflow=0. Subtract 0x8000−0x0001 → 0x7FFF, cout=1, overflow=1. Add 0x7FFF+0x0001 → 0x8000, overflow=1.
- Subtract 0xABCD−0xABCD → result 0, zero=1, cout=1. Add 0xFFFF+0x0001 → 0, zero=1, cout=1, overflow=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles → outputs frozen, in_ready=0.
  - in_valid pulses during RUN/DONE are not accepted.
  - Release → IDLE next edge.
- Assert rst_n=0 in the 2nd RUN cycle → out_valid=0 and all outputs 0 immediately. After release, a fresh 0x0001+0x0001 returns 0x0002.
- Parameter sweep:
  - WIDTH=16, DIGIT=1 → latency 16.
  - WIDTH=16, DIGIT=16 → latency 1.
  - WIDTH=4, DIGIT=4, subtract 9−3 → result 6, cout=1.
  - Random operands checked against a golden model in all configurations.
